// File: rtl/mod10_counter.sv
// mod10_counter_core: free-running decimal (0-9) counter with a terminal-count flag.
// Optional seven-segment decoder output is compiled in when MOD10_SEG_EN is defined;
// SEG_ACTIVE_LOW selects the segment polarity of that decoder.
module mod10_counter_core #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] count,
    output logic       tc
`ifdef MOD10_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    // Digit register: reset wins, 9 and any illegal code (10-15) fall back to 0, else increment
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (count >= 4'd9) begin
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

    // Terminal count is a pure decode of the registered digit, so 10-15 can never raise it
    assign tc = (count == 4'd9);

`ifdef MOD10_SEG_EN
    logic [6:0] seg_lit;

    // Active-high digit decode, bit order {g,f,e,d,c,b,a}; illegal codes blank the display
    always_comb begin
        seg_lit = 7'b0000000;
        case (count)
            4'd0: seg_lit = 7'b0111111;
            4'd1: seg_lit = 7'b0000110;
            4'd2: seg_lit = 7'b1011011;
            4'd3: seg_lit = 7'b1001111;
            4'd4: seg_lit = 7'b1100110;
            4'd5: seg_lit = 7'b1101101;
            4'd6: seg_lit = 7'b1111101;
            4'd7: seg_lit = 7'b0000111;
            4'd8: seg_lit = 7'b1111111;
            4'd9: seg_lit = 7'b1101111;
            default: seg_lit = 7'b0000000;
        endcase
    end

    // Common-anode displays want a 0 to light a segment, so invert the whole pattern
    assign seg = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
`endif

endmodule

// File: tb/tb_mod10_counter_core.sv
// Self-checking bench for mod10_counter_core. Build with MOD10_SEG_EN defined to also
// exercise the seven-segment outputs (a second instance covers the active-low polarity).
module tb_mod10_counter_core;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic       tc;
`ifdef MOD10_SEG_EN
    logic [6:0] seg;
    logic [3:0] count_low;
    logic       tc_low;
    logic [6:0] seg_low;
`endif

    int vectors;
    int miscompares;
    int model;
    int tc_highs;

    mod10_counter_core #(.SEG_ACTIVE_LOW(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .tc    (tc)
`ifdef MOD10_SEG_EN
        ,
        .seg   (seg)
`endif
    );

`ifdef MOD10_SEG_EN
    mod10_counter_core #(.SEG_ACTIVE_LOW(1'b1)) dut_low (
        .clk   (clk),
        .reset (reset),
        .count (count_low),
        .tc    (tc_low),
        .seg   (seg_low)
    );
`endif

    // 10 ns clock, first rising edge at 5 ns
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Expected active-high segment pattern for a digit value; anything else is blank
    function automatic logic [6:0] expectedSeg(input int v);
        logic [6:0] table_val [10];
        table_val[0] = 7'b0111111;
        table_val[1] = 7'b0000110;
        table_val[2] = 7'b1011011;
        table_val[3] = 7'b1001111;
        table_val[4] = 7'b1100110;
        table_val[5] = 7'b1101101;
        table_val[6] = 7'b1111101;
        table_val[7] = 7'b0000111;
        table_val[8] = 7'b1111111;
        table_val[9] = 7'b1101111;
        if (v >= 0 && v <= 9) return table_val[v];
        return 7'b0000000;
    endfunction

    // Drive reset for one rising edge, advance the reference model, then settle at the falling edge
    task automatic applyStimulus(input logic r);
        reset = r;
        @(posedge clk);
        if (r) model = 0;
        else if (model >= 9) model = 0;
        else model = model + 1;
        @(negedge clk);
    endtask

    // Compare every output against the reference model
    task automatic checkOutput(input string tag);
        logic [3:0] exp_count;
        logic       exp_tc;
        exp_count = 4'(model);
        exp_tc    = (model == 9);
        vectors++;
        assert (count === exp_count) else begin
            miscompares++;
            $error("[TB] FAIL %s count actual=%0d required=%0d", tag, count, exp_count);
        end
        vectors++;
        assert (tc === exp_tc) else begin
            miscompares++;
            $error("[TB] FAIL %s tc actual=%0b required=%0b", tag, tc, exp_tc);
        end
`ifdef MOD10_SEG_EN
        vectors++;
        assert (seg === expectedSeg(model)) else begin
            miscompares++;
            $error("[TB] FAIL %s seg actual=%07b required=%07b", tag, seg, expectedSeg(model));
        end
        vectors++;
        assert (seg_low === ~expectedSeg(model)) else begin
            miscompares++;
            $error("[TB] FAIL %s seg_low actual=%07b required=%07b", tag, seg_low, ~expectedSeg(model));
        end
        vectors++;
        assert (count_low === exp_count) else begin
            miscompares++;
            $error("[TB] FAIL %s count_low actual=%0d required=%0d", tag, count_low, exp_count);
        end
`endif
    endtask

    // Directed scenarios followed by randomized reset traffic
    initial begin
        vectors     = 0;
        miscompares = 0;
        model       = 0;
        reset       = 1'b1;

        // Reset held across the 5 ns edge, released at 10 ns
        applyStimulus(1'b1);
        checkOutput("reset");
        applyStimulus(1'b0);
        checkOutput("first_count");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0);
            checkOutput("count_up");
        end

        // Free run 20 cycles: count follows the model and tc is high exactly twice
        tc_highs = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0);
            checkOutput("free_run");
            if (tc) tc_highs++;
        end
        vectors++;
        assert (tc_highs === 2) else begin
            miscompares++;
            $error("[TB] FAIL tc_period actual=%0d required=2", tc_highs);
        end

        // Bring count to 9, then reset must override the wrap
        while (model != 9) begin
            applyStimulus(1'b0);
            checkOutput("to_nine");
        end
        applyStimulus(1'b1);
        checkOutput("reset_at_nine");
        applyStimulus(1'b0);
        checkOutput("after_reset_at_nine");

        // Upset the register to an illegal code and check recovery to 0
        force dut.count = 4'd12;
`ifdef MOD10_SEG_EN
        force dut_low.count = 4'd12;
`endif
        #1;
        model = 12;
        checkOutput("illegal_held");
        release dut.count;
`ifdef MOD10_SEG_EN
        release dut_low.count;
`endif
        applyStimulus(1'b0);
        checkOutput("illegal_recover");
        applyStimulus(1'b0);
        checkOutput("illegal_next");

        // Random reset pulses while counting
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
